// File: rtl/pps_sram_bridge.sv
// Shared single-port async SRAM front-end for the PPS core.
// Arbitrates fetch and load/store ports; all pad outputs registered.
module pps_sram_bridge #(
  parameter int ADDR_W        = 18,
  parameter int WAIT_CYCLES   = 1,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        bwe,
  output logic [31:0]       data_rdata,
  output logic              data_ready,
  output logic              stall,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_dq_in,
  output logic [31:0]       sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("pps_sram_bridge: WAIT_CYCLES must be 0..15");
  end

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              gnt_data, gnt_d;
  logic              rr_data, rr_d;
  logic              store, store_d;
  logic              pick, op_st, cap;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       dq_out_d;
  logic [3:0]        be_d;
  logic              ce_d, oe_d, we_d, dq_oe_d;

  wire unused_ok = &{1'b0, inst_addr, data_addr};

  assign inst_ready = (state == DONE) & ~gnt_data;
  assign data_ready = (state == DONE) & gnt_data;
  assign stall = (inst_req & ~inst_ready) | (data_req & ~data_ready);

  // rr_data set means the data port wins the next tie
  assign pick  = data_req &
                 (~inst_req | (DATA_PRIORITY ? 1'b1 : rr_data));
  assign op_st = pick & (|bwe);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    gnt_d    = gnt_data;
    rr_d     = rr_data;
    store_d  = store;
    addr_d   = sram_addr;
    dq_out_d = sram_dq_out;
    be_d     = sram_be_n;
    ce_d     = 1'b1;
    oe_d     = 1'b1;
    we_d     = 1'b1;
    dq_oe_d  = 1'b0;
    cap      = 1'b0;
    unique case (state)
      IDLE: begin
        if (inst_req | data_req) begin
          gnt_d   = pick;
          rr_d    = ~pick;
          store_d = op_st;
          addr_d  = pick ? data_addr[ADDR_W+1:2]
                         : inst_addr[ADDR_W+1:2];
          if (op_st) dq_out_d = data_wdata;
          be_d    = op_st ? ~bwe : 4'h0;
          ce_d    = 1'b0;
          oe_d    = op_st;
          we_d    = ~op_st;
          dq_oe_d = op_st;
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ce_d    = 1'b0;
        dq_oe_d = store;
        if (cnt == LAST) begin
          cap     = ~store;
          state_d = DONE;
        end else begin
          oe_d  = store;
          we_d  = ~store;
          cnt_d = cnt + 4'd1;
        end
      end
      DONE: begin
        be_d    = 4'hF;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      gnt_data    <= 1'b0;
      rr_data     <= 1'b0;
      store       <= 1'b0;
      inst_rdata  <= 32'h0;
      data_rdata  <= 32'h0;
      sram_addr   <= '0;
      sram_dq_out <= 32'h0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_be_n   <= 4'hF;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      gnt_data    <= gnt_d;
      rr_data     <= rr_d;
      store       <= store_d;
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= dq_oe_d;
      sram_ce_n   <= ce_d;
      sram_oe_n   <= oe_d;
      sram_we_n   <= we_d;
      sram_be_n   <= be_d;
      if (cap && gnt_data)  data_rdata <= sram_dq_in;
      if (cap && !gnt_data) inst_rdata <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_pps_sram_bridge.sv
// Directed bench for pps_sram_bridge: four configurations,
// each with its own behavioural async SRAM.
module tb_pps_sram_bridge;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  logic        inst_req[N], data_req[N], inst_ready[N], data_ready[N];
  logic        stall[N], dq_oe[N], ce_n[N], oe_n[N], we_n[N];
  logic [31:0] inst_addr[N], inst_rdata[N], data_addr[N];
  logic [31:0] data_wdata[N], data_rdata[N], dq_out[N], dq_in[N];
  logic [3:0]  bwe[N], be_n[N];
  logic [17:0] saddr[N];
  logic [31:0] mem[N][64];

  int checks = 0;
  int errors = 0;

  logic [63:0] ce_v, oe_v, we_v, oq_v, ir_v, dr_v, st_v;
  logic [5:0]  order;
  int          ngr;
  bit          both_rdy, got;
  logic [31:0] ird, drd, dqo_done;
  logic [17:0] a_first;
  logic [3:0]  be_first;

  always #5 clk = ~clk;

  // u0: W=1 priority, u1: W=0, u2: W=1 round-robin, u3: W=15
  pps_sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(1), .DATA_PRIORITY(1'b1)) u0 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[0]), .inst_addr(inst_addr[0]),
    .inst_rdata(inst_rdata[0]), .inst_ready(inst_ready[0]),
    .data_req(data_req[0]), .data_addr(data_addr[0]),
    .data_wdata(data_wdata[0]), .bwe(bwe[0]),
    .data_rdata(data_rdata[0]), .data_ready(data_ready[0]),
    .stall(stall[0]), .sram_addr(saddr[0]), .sram_dq_in(dq_in[0]),
    .sram_dq_out(dq_out[0]), .sram_dq_oe(dq_oe[0]), .sram_ce_n(ce_n[0]),
    .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_be_n(be_n[0])
  );

  pps_sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(0), .DATA_PRIORITY(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[1]), .inst_addr(inst_addr[1]),
    .inst_rdata(inst_rdata[1]), .inst_ready(inst_ready[1]),
    .data_req(data_req[1]), .data_addr(data_addr[1]),
    .data_wdata(data_wdata[1]), .bwe(bwe[1]),
    .data_rdata(data_rdata[1]), .data_ready(data_ready[1]),
    .stall(stall[1]), .sram_addr(saddr[1]), .sram_dq_in(dq_in[1]),
    .sram_dq_out(dq_out[1]), .sram_dq_oe(dq_oe[1]), .sram_ce_n(ce_n[1]),
    .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_be_n(be_n[1])
  );

  pps_sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(1), .DATA_PRIORITY(1'b0)) u2 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[2]), .inst_addr(inst_addr[2]),
    .inst_rdata(inst_rdata[2]), .inst_ready(inst_ready[2]),
    .data_req(data_req[2]), .data_addr(data_addr[2]),
    .data_wdata(data_wdata[2]), .bwe(bwe[2]),
    .data_rdata(data_rdata[2]), .data_ready(data_ready[2]),
    .stall(stall[2]), .sram_addr(saddr[2]), .sram_dq_in(dq_in[2]),
    .sram_dq_out(dq_out[2]), .sram_dq_oe(dq_oe[2]), .sram_ce_n(ce_n[2]),
    .sram_oe_n(oe_n[2]), .sram_we_n(we_n[2]), .sram_be_n(be_n[2])
  );

  pps_sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(15), .DATA_PRIORITY(1'b1)) u3 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[3]), .inst_addr(inst_addr[3]),
    .inst_rdata(inst_rdata[3]), .inst_ready(inst_ready[3]),
    .data_req(data_req[3]), .data_addr(data_addr[3]),
    .data_wdata(data_wdata[3]), .bwe(bwe[3]),
    .data_rdata(data_rdata[3]), .data_ready(data_ready[3]),
    .stall(stall[3]), .sram_addr(saddr[3]), .sram_dq_in(dq_in[3]),
    .sram_dq_out(dq_out[3]), .sram_dq_oe(dq_oe[3]), .sram_ce_n(ce_n[3]),
    .sram_oe_n(oe_n[3]), .sram_we_n(we_n[3]), .sram_be_n(be_n[3])
  );

  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      if (!ce_n[k] && !we_n[k])
        for (int b = 0; b < 4; b++)
          if (!be_n[k][b])
            mem[k][saddr[k][5:0]][8*b +: 8] = dq_out[k][8*b +: 8];
  end

  always_comb begin
    for (int k = 0; k < N; k++)
      dq_in[k] = oe_n[k] ? 32'hDEAD_BEEF : mem[k][saddr[k][5:0]];
  end

  // Records one bit per cycle; keep_n>0 re-presents both requests
  // until keep_n grants have completed, else drops the served port.
  task automatic run(input int k, input int n, input int keep_n);
    bit ri, rd;
    ce_v = '0; oe_v = '0; we_v = '0; oq_v = '0;
    ir_v = '0; dr_v = '0; st_v = '0;
    order = '0; ngr = 0; both_rdy = 0; got = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ce_v[c] = ~ce_n[k];
      oe_v[c] = ~oe_n[k];
      we_v[c] = ~we_n[k];
      oq_v[c] = dq_oe[k];
      ir_v[c] = inst_ready[k];
      dr_v[c] = data_ready[k];
      st_v[c] = stall[k];
      ri = inst_ready[k];
      rd = data_ready[k];
      if (!ce_n[k] && !got) begin
        a_first = saddr[k]; be_first = be_n[k]; got = 1;
      end
      if (ri && rd) both_rdy = 1;
      if (ri) begin
        ird = inst_rdata[k];
        if (ngr < 6) order[ngr] = 1'b0;
        ngr++;
      end
      if (rd) begin
        drd = data_rdata[k]; dqo_done = dq_out[k];
        if (ngr < 6) order[ngr] = 1'b1;
        ngr++;
      end
      @(posedge clk); #1;
      if (keep_n > 0) begin
        if ((ri || rd) && ngr >= keep_n) begin
          inst_req[k] = 0; data_req[k] = 0;
        end
      end else begin
        if (ri) inst_req[k] = 0;
        if (rd) data_req[k] = 0;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (inst_ready[0] !== 1'b0) begin errors++;
      $display("FAIL rst_inst_ready: got %b want 0", inst_ready[0]); end
    checks++; if (data_ready[0] !== 1'b0) begin errors++;
      $display("FAIL rst_data_ready: got %b want 0", data_ready[0]); end
    checks++; if (inst_rdata[0] !== 32'h0) begin errors++;
      $display("FAIL rst_inst_rdata: got %h want 0", inst_rdata[0]); end
    checks++; if (data_rdata[0] !== 32'h0) begin errors++;
      $display("FAIL rst_data_rdata: got %h want 0", data_rdata[0]); end
    checks++;
    if ({ce_n[0], oe_n[0], we_n[0]} !== 3'b111) begin errors++;
      $display("FAIL rst_ctl_n: got %b want 111",
               {ce_n[0], oe_n[0], we_n[0]}); end
    checks++; if (be_n[0] !== 4'hF) begin errors++;
      $display("FAIL rst_be_n: got %h want f", be_n[0]); end
    checks++; if (dq_oe[0] !== 1'b0) begin errors++;
      $display("FAIL rst_dq_oe: got %b want 0", dq_oe[0]); end
    checks++; if (saddr[0] !== 18'h0) begin errors++;
      $display("FAIL rst_addr: got %h want 0", saddr[0]); end
    checks++; if (dq_out[0] !== 32'h0) begin errors++;
      $display("FAIL rst_dq_out: got %h want 0", dq_out[0]); end
    checks++; if (stall[0] !== 1'b0) begin errors++;
      $display("FAIL rst_stall: got %b want 0", stall[0]); end
  endtask

  task automatic test_fetch;
    @(posedge clk); #1;
    inst_addr[0] = 32'h10; inst_req[0] = 1;
    run(0, 6, 0);
    checks++; if (a_first !== 18'd4) begin errors++;
      $display("FAIL fetch_addr: got %0d want 4", a_first); end
    checks++; if (oe_v[5:0] !== 6'b000110) begin errors++;
      $display("FAIL fetch_oe: got %b want 000110", oe_v[5:0]); end
    checks++; if (ir_v[5:0] !== 6'b001000) begin errors++;
      $display("FAIL fetch_ready: got %b want 001000", ir_v[5:0]); end
    checks++; if (st_v[5:0] !== 6'b000111) begin errors++;
      $display("FAIL fetch_stall: got %b want 000111", st_v[5:0]); end
    checks++; if (ird !== 32'h2402_0005) begin errors++;
      $display("FAIL fetch_rdata: got %h want 24020005", ird); end
    checks++; if (dr_v[5:0] !== 6'b0) begin errors++;
      $display("FAIL fetch_no_dready: got %b want 0", dr_v[5:0]); end
  endtask

  task automatic test_byte_store;
    @(posedge clk); #1;
    data_addr[1] = 32'h22; bwe[1] = 4'b0100;
    data_wdata[1] = 32'h00AB_0000; data_req[1] = 1;
    run(1, 5, 0);
    checks++; if (a_first !== 18'd8) begin errors++;
      $display("FAIL st_addr: got %0d want 8", a_first); end
    checks++; if (be_first !== 4'b1011) begin errors++;
      $display("FAIL st_be_n: got %b want 1011", be_first); end
    checks++; if (we_v[4:0] !== 5'b00010) begin errors++;
      $display("FAIL st_we: got %b want 00010", we_v[4:0]); end
    checks++; if (oq_v[4:0] !== 5'b00110) begin errors++;
      $display("FAIL st_dq_oe: got %b want 00110", oq_v[4:0]); end
    checks++; if (dr_v[4:0] !== 5'b00100) begin errors++;
      $display("FAIL st_ready: got %b want 00100", dr_v[4:0]); end
    checks++; if (dqo_done !== 32'h00AB_0000) begin errors++;
      $display("FAIL st_hold_dq: got %h want 00ab0000", dqo_done); end
    checks++; if (mem[1][8] !== 32'h11AB_3344) begin errors++;
      $display("FAIL st_mem: got %h want 11ab3344", mem[1][8]); end
    bwe[1] = 4'b0000; data_req[1] = 1;
    run(1, 5, 0);
    checks++; if (drd !== 32'h11AB_3344) begin errors++;
      $display("FAIL st_readback: got %h want 11ab3344", drd); end
    checks++; if (oe_v[4:0] !== 5'b00010) begin errors++;
      $display("FAIL ld_oe_w0: got %b want 00010", oe_v[4:0]); end
  endtask

  task automatic test_tie_priority;
    @(posedge clk); #1;
    inst_addr[0] = 32'h10; inst_req[0] = 1;
    data_addr[0] = 32'h40; bwe[0] = 4'b0; data_req[0] = 1;
    run(0, 10, 0);
    checks++; if (dr_v[9:0] !== 10'b0000001000) begin errors++;
      $display("FAIL tie_dready: got %b want 0000001000", dr_v[9:0]); end
    checks++; if (ir_v[9:0] !== 10'b0010000000) begin errors++;
      $display("FAIL tie_iready: got %b want 0010000000", ir_v[9:0]); end
    checks++; if (st_v[9:0] !== 10'b0001111111) begin errors++;
      $display("FAIL tie_stall: got %b want 0001111111", st_v[9:0]); end
    checks++; if (ce_v[9:0] !== 10'b0011101110) begin errors++;
      $display("FAIL tie_ce: got %b want 0011101110", ce_v[9:0]); end
    checks++; if (drd !== 32'h1234_5678) begin errors++;
      $display("FAIL tie_drdata: got %h want 12345678", drd); end
    checks++; if (ird !== 32'h2402_0005) begin errors++;
      $display("FAIL tie_irdata: got %h want 24020005", ird); end
  endtask

  task automatic test_round_robin;
    @(posedge clk); #1;
    inst_addr[2] = 32'h10; inst_req[2] = 1;
    data_addr[2] = 32'h20; bwe[2] = 4'b0; data_req[2] = 1;
    run(2, 28, 6);
    checks++; if (ngr !== 6) begin errors++;
      $display("FAIL rr_grants: got %0d want 6", ngr); end
    checks++; if (order !== 6'b101010) begin errors++;
      $display("FAIL rr_order: got %b want 101010", order); end
    checks++; if (both_rdy !== 1'b0) begin errors++;
      $display("FAIL rr_one_ready: got %b want 0", both_rdy); end
    checks++;
    if ({ird, drd} !== {32'h0000_0001, 32'h0000_0002}) begin errors++;
      $display("FAIL rr_rdata: got %h %h want 1 2", ird, drd); end
  endtask

  task automatic test_long_wait;
    @(posedge clk); #1;
    data_addr[3] = 32'h0; bwe[3] = 4'b0; data_req[3] = 1;
    run(3, 20, 0);
    checks++; if (oe_v[19:0] !== 20'h1FFFE) begin errors++;
      $display("FAIL w15_oe: got %h want 1fffe", oe_v[19:0]); end
    checks++; if (dr_v[19:0] !== 20'h20000) begin errors++;
      $display("FAIL w15_ready: got %h want 20000", dr_v[19:0]); end
    checks++; if (ce_v[19:0] !== 20'h3FFFE) begin errors++;
      $display("FAIL w15_ce: got %h want 3fffe", ce_v[19:0]); end
    checks++; if (drd !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL w15_rdata: got %h want cafef00d", drd); end
  endtask

  task automatic test_reset_abort;
    @(posedge clk); #1;
    data_addr[0] = 32'h30; bwe[0] = 4'hF;
    data_wdata[0] = 32'h55AA_55AA; data_req[0] = 1;
    @(posedge clk); #1;
    checks++; if (we_n[0] !== 1'b0) begin errors++;
      $display("FAIL ab_pre_we: got %b want 0", we_n[0]); end
    #2 rst = 0;
    #1;
    checks++; if (we_n[0] !== 1'b1) begin errors++;
      $display("FAIL ab_we_n: got %b want 1", we_n[0]); end
    checks++; if (dq_oe[0] !== 1'b0) begin errors++;
      $display("FAIL ab_dq_oe: got %b want 0", dq_oe[0]); end
    checks++; if (ce_n[0] !== 1'b1) begin errors++;
      $display("FAIL ab_ce_n: got %b want 1", ce_n[0]); end
    data_req[0] = 0;
    @(negedge clk); rst = 1;
    run(0, 8, 0);
    checks++; if (dr_v[7:0] !== 8'h0) begin errors++;
      $display("FAIL ab_no_ready: got %b want 0", dr_v[7:0]); end
    checks++; if (ce_v[7:0] !== 8'h0) begin errors++;
      $display("FAIL ab_no_access: got %b want 0", ce_v[7:0]); end
  endtask

  initial begin
    rst = 1;
    for (int k = 0; k < N; k++) begin
      inst_req[k] = 0; data_req[k] = 0;
      inst_addr[k] = 0; data_addr[k] = 0;
      data_wdata[k] = 0; bwe[k] = 0;
      for (int a = 0; a < 64; a++) mem[k][a] = 32'h0;
    end
    mem[0][4]  = 32'h2402_0005;
    mem[0][16] = 32'h1234_5678;
    mem[1][8]  = 32'h1122_3344;
    mem[2][4]  = 32'h0000_0001;
    mem[2][8]  = 32'h0000_0002;
    mem[3][0]  = 32'hCAFE_F00D;
    #2 rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    test_reset();
    test_fetch();
    test_byte_store();
    test_tie_priority();
    test_round_robin();
    test_long_wait();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
